// File: rtl/inst_encoder.sv
// RV32I instruction encoder: DecodedInst in, instruction-memory write stream out.
// Optional macro ENC_LI_EXPAND_EN expands wide OPIMM ADD immediates into LUI+ADDI.
package inst_encoder_pkg;
  typedef enum logic [3:0] {
    IT_OP, IT_OPIMM, IT_LUI, IT_AUIPC, IT_JAL, IT_JALR,
    IT_BRANCH, IT_LOAD, IT_STORE, IT_UNSUPPORTED
  } itype_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_UNSUPPORTED
  } alu_func_e;

  typedef enum logic [2:0] {
    BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_UNSUPPORTED
  } br_func_e;

  typedef enum logic [2:0] {
    MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU, MEM_UNSUPPORTED
  } mem_func_e;

  typedef struct packed {
    itype_e      itype;
    alu_func_e   alu_func;
    br_func_e    br_func;
    mem_func_e   mem_func;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] imm;
  } decoded_inst_t;
endpackage

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  decoded_inst_t     din,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_pulse,
  output logic              err_sticky
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic {S_IDLE, S_SECOND} state_e;

  state_e            r_state, w_next_state;
  logic [31:0]       r_out_data, r_second;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_out_valid, r_err_pulse, r_err_sticky;

  logic        w_in_ready, w_accept, w_xfer;
  logic [31:0] w_word0, w_word1;
  logic        w_two, w_reject;
  logic [2:0]  w_alu_f3, w_br_f3, w_mem_f3;
  logic [6:0]  w_alu_f7;
  logic        w_alu_shift, w_alu_bad, w_br_bad, w_mem_bad;
  logic        w_fit12, w_fit13, w_fit21, w_fit_sh;

  // A value fits an N-bit signed field when all bits above N-1 are copies of the sign.
  assign w_fit12  = (&din.imm[31:11]) | ~(|din.imm[31:11]);
  assign w_fit13  = (&din.imm[31:12]) | ~(|din.imm[31:12]);
  assign w_fit21  = (&din.imm[31:20]) | ~(|din.imm[31:20]);
  assign w_fit_sh = ~(|din.imm[31:5]);

`ifdef ENC_LI_EXPAND_EN
  logic [19:0] w_hi;
  logic [31:0] w_lo;
  assign w_hi = din.imm[31:12] + {19'd0, din.imm[11]};
  assign w_lo = din.imm - {w_hi, 12'd0};
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_alu_f3 = 3'b000; w_alu_f7 = 7'b0000000; w_alu_shift = 1'b0; w_alu_bad = 1'b0;
    case (din.alu_func)
      ALU_ADD:  w_alu_f3 = 3'b000;
      ALU_SUB:  begin w_alu_f3 = 3'b000; w_alu_f7 = 7'b0100000; end
      ALU_SLL:  begin w_alu_f3 = 3'b001; w_alu_shift = 1'b1; end
      ALU_SLT:  w_alu_f3 = 3'b010;
      ALU_SLTU: w_alu_f3 = 3'b011;
      ALU_XOR:  w_alu_f3 = 3'b100;
      ALU_SRL:  begin w_alu_f3 = 3'b101; w_alu_shift = 1'b1; end
      ALU_SRA:  begin w_alu_f3 = 3'b101; w_alu_f7 = 7'b0100000; w_alu_shift = 1'b1; end
      ALU_OR:   w_alu_f3 = 3'b110;
      ALU_AND:  w_alu_f3 = 3'b111;
      default:  w_alu_bad = 1'b1;
    endcase

    w_br_f3 = 3'b000; w_br_bad = 1'b0;
    case (din.br_func)
      BR_EQ:   w_br_f3 = 3'b000;
      BR_NE:   w_br_f3 = 3'b001;
      BR_LT:   w_br_f3 = 3'b100;
      BR_GE:   w_br_f3 = 3'b101;
      BR_LTU:  w_br_f3 = 3'b110;
      BR_GEU:  w_br_f3 = 3'b111;
      default: w_br_bad = 1'b1;
    endcase

    w_mem_f3 = 3'b000; w_mem_bad = 1'b0;
    case (din.mem_func)
      MEM_B:   w_mem_f3 = 3'b000;
      MEM_H:   w_mem_f3 = 3'b001;
      MEM_W:   w_mem_f3 = 3'b010;
      MEM_BU:  w_mem_f3 = 3'b100;
      MEM_HU:  w_mem_f3 = 3'b101;
      default: w_mem_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_word0 = 32'd0; w_word1 = 32'd0; w_two = 1'b0; w_reject = 1'b0;
    case (din.itype)
      IT_OP: begin
        w_reject = w_alu_bad;
        w_word0  = {w_alu_f7, din.src2, din.src1, w_alu_f3, din.dst, OPC_OP};
      end
      IT_OPIMM: begin
        if (w_alu_bad || din.alu_func == ALU_SUB) begin
          w_reject = 1'b1;
        end else if (w_alu_shift) begin
          w_reject = !w_fit_sh;
          w_word0  = {w_alu_f7, din.imm[4:0], din.src1, w_alu_f3, din.dst, OPC_OPIMM};
        end else if (w_fit12) begin
          w_word0 = {din.imm[11:0], din.src1, w_alu_f3, din.dst, OPC_OPIMM};
`ifdef ENC_LI_EXPAND_EN
        end else if (din.alu_func == ALU_ADD && din.src1 == 5'd0) begin
          // A zero low part needs no ADDI; the LUI alone reproduces the value.
          w_word0 = {w_hi, din.dst, OPC_LUI};
          w_two   = (w_lo != 32'd0);
          w_word1 = {w_lo[11:0], din.dst, 3'b000, din.dst, OPC_OPIMM};
`endif
        end else begin
          w_reject = 1'b1;
        end
      end
      IT_LUI, IT_AUIPC: begin
        w_reject = (din.imm[11:0] != 12'd0);
        w_word0  = {din.imm[31:12], din.dst, (din.itype == IT_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      IT_JAL: begin
        w_reject = !w_fit21 || din.imm[0];
        w_word0  = {din.imm[20], din.imm[10:1], din.imm[11], din.imm[19:12], din.dst, OPC_JAL};
      end
      IT_JALR: begin
        w_reject = !w_fit12;
        w_word0  = {din.imm[11:0], din.src1, 3'b000, din.dst, OPC_JALR};
      end
      IT_BRANCH: begin
        w_reject = w_br_bad || !w_fit13 || din.imm[0];
        w_word0  = {din.imm[12], din.imm[10:5], din.src2, din.src1, w_br_f3,
                    din.imm[4:1], din.imm[11], OPC_BRANCH};
      end
      IT_LOAD: begin
        w_reject = w_mem_bad || !w_fit12;
        w_word0  = {din.imm[11:0], din.src1, w_mem_f3, din.dst, OPC_LOAD};
      end
      IT_STORE: begin
        // Stores have no unsigned variants.
        w_reject = w_mem_bad || w_mem_f3[2] || !w_fit12;
        w_word0  = {din.imm[11:5], din.src2, din.src1, w_mem_f3, din.imm[4:0], OPC_STORE};
      end
      default: w_reject = 1'b1;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    w_accept     = in_valid && w_in_ready;
    w_xfer       = r_out_valid && out_ready;
    case (r_state)
      S_IDLE:   if (w_accept && !w_reject && w_two) w_next_state = S_SECOND;
      S_SECOND: if (w_xfer) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_out_data   <= 32'd0;
      r_second     <= 32'd0;
      r_out_addr   <= ADDR_W'(BASE_ADDR);
      r_out_valid  <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_pulse  <= w_accept && w_reject;
      r_err_sticky <= r_err_sticky | (w_accept && w_reject);
      if (w_xfer) r_out_addr <= r_out_addr + ADDR_W'(4);
      if (r_state == S_SECOND && w_xfer) begin
        r_out_data <= r_second;
      end else if (w_accept && !w_reject) begin
        r_out_data  <= w_word0;
        r_second    <= w_word1;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_data   = r_out_data;
  assign out_addr   = r_out_addr;
  assign out_valid  = r_out_valid;
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder; follows ENC_LI_EXPAND_EN if defined.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst;
  decoded_inst_t din;
  logic          in_valid, in_ready, out_valid, out_ready, err_pulse, err_sticky;
  logic [31:0]   out_data, out_addr;
  logic [31:0]   exp_addr;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  inst_encoder #(.BASE_ADDR(BASE), .ADDR_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready),
    .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic decoded_inst_t mk(input itype_e it, input alu_func_e af, input br_func_e bf,
                                       input mem_func_e mf, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm);
    decoded_inst_t d;
    d.itype = it; d.alu_func = af; d.br_func = bf; d.mem_func = mf;
    d.dst = rd; d.src1 = rs1; d.src2 = rs2; d.imm = imm;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input decoded_inst_t d);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    din = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] data);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, data);
    check({tag, "_addr"}, out_addr, exp_addr);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    exp_addr = exp_addr + 32'd4;
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    check({tag, "_next_addr"}, out_addr, exp_addr);
  endtask

  task automatic expect_word(input string tag, input decoded_inst_t d, input logic [31:0] data);
    send(tag, d);
    chk_out(tag, data);
    drain(tag);
  endtask

  task automatic expect_reject(input string tag, input decoded_inst_t d);
    send(tag, d);
    check({tag, "_err_pulse"}, 32'(err_pulse), 32'd1);
    check({tag, "_err_sticky"}, 32'(err_sticky), 32'd1);
    check({tag, "_no_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_addr_held"}, out_addr, exp_addr);
    tick();
    check({tag, "_pulse_end"}, 32'(err_pulse), 32'd0);
    check({tag, "_sticky_hold"}, 32'(err_sticky), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    repeat (2) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", out_addr, BASE);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    exp_addr = BASE;
    tick();

    expect_word("addi5", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'd5), 32'h00500093);

    // Back-to-back SUB then BEQ with out_ready held high.
    send("sub", mk(IT_OP, ALU_SUB, BR_EQ, MEM_W, 5'd3, 5'd1, 5'd2, 32'd0));
    chk_out("sub", 32'h402081B3);
    send("beq", mk(IT_BRANCH, ALU_ADD, BR_EQ, MEM_W, 5'd0, 5'd1, 5'd2, 32'd8));
    exp_addr = exp_addr + 32'd4;
    chk_out("beq", 32'h00208463);
    drain("beq");

    // Stall: sink refuses the word for three cycles.
    out_ready = 1'b0;
    send("stall", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'd5));
    for (int i = 0; i < 3; i++) begin
      chk_out("stall", 32'h00500093);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (i < 2) tick();
    end
    drain("stall");

    expect_word("srai", mk(IT_OPIMM, ALU_SRA, BR_EQ, MEM_W, 5'd2, 5'd3, 5'd0, 32'd7), 32'h4071D113);
    expect_word("sw", mk(IT_STORE, ALU_ADD, BR_EQ, MEM_W, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC), 32'hFE312E23);
    expect_word("lw", mk(IT_LOAD, ALU_ADD, BR_EQ, MEM_W, 5'd4, 5'd5, 5'd0, 32'hFFFF_FFFF), 32'hFFF2A203);
    expect_word("jal", mk(IT_JAL, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'd2048), 32'h001000EF);
    expect_word("addi_max", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'd2047), 32'h7FF00093);
    expect_word("addi_min", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800), 32'h80000093);
    expect_word("beq_max", mk(IT_BRANCH, ALU_ADD, BR_EQ, MEM_W, 5'd0, 5'd1, 5'd2, 32'd4094), 32'h7E208FE3);

`ifdef ENC_LI_EXPAND_EN
    send("li", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd5, 5'd0, 5'd0, 32'h1234_5678));
    chk_out("li_lui", 32'h123452B7);
    check("li_in_ready_lo", 32'(in_ready), 32'd0);
    tick();
    exp_addr = exp_addr + 32'd4;
    chk_out("li_addi", 32'h67828293);
    check("li_in_ready_back", 32'(in_ready), 32'd1);
    drain("li");
    send("li0", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd5, 5'd0, 5'd0, 32'h1234_5000));
    chk_out("li0_lui", 32'h123452B7);
    check("li0_idle", 32'(in_ready), 32'd1);
    drain("li0");
`else
    expect_reject("li_rej", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd5, 5'd0, 5'd0, 32'h1234_5678));
`endif

    expect_reject("br_odd", mk(IT_BRANCH, ALU_ADD, BR_EQ, MEM_W, 5'd0, 5'd1, 5'd2, 32'd3));
    expect_word("after_rej", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'd5), 32'h00500093);
    expect_reject("br_far", mk(IT_BRANCH, ALU_ADD, BR_EQ, MEM_W, 5'd0, 5'd1, 5'd2, 32'd4096));
    expect_reject("slli32", mk(IT_OPIMM, ALU_SLL, BR_EQ, MEM_W, 5'd1, 5'd1, 5'd0, 32'd32));
    expect_reject("addi_rs1", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd1, 5'd0, 32'd2048));
    expect_reject("lui_low", mk(IT_LUI, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'h0000_1001));
    expect_reject("itype_bad", mk(IT_UNSUPPORTED, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'd0));

    // Reset while a word is held (and, with expansion, a second word pending).
    out_ready = 1'b0;
`ifdef ENC_LI_EXPAND_EN
    send("mid", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd5, 5'd0, 5'd0, 32'h1234_5678));
`else
    send("mid", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'd5));
`endif
    check("mid_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sticky", 32'(err_sticky), 32'd0);
    check("mid_rst_addr", out_addr, BASE);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    exp_addr = BASE;
    expect_word("post_rst", mk(IT_OPIMM, ALU_ADD, BR_EQ, MEM_W, 5'd1, 5'd0, 5'd0, 32'd5), 32'h00500093);
    check("post_rst_sticky", 32'(err_sticky), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the CPU decode stage: accepts one DecodedInst per handshake and emits the RV32I 32-bit instruction word(s) that decode back to it.
- Stream output carries a word address, so the block drives the instruction-memory write port of the program loader / test-program builder.
- Registered, single-entry output buffer. Small FSM handles two-word expansion.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.
- ADDR_W, 32, width of out_addr; wraps modulo 2^ADDR_W.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous active-high reset
- din  input  DecodedInst  decoded instruction (itype, alu_func, br_func, mem_func, dst, src1, src2, imm)
- in_valid  input  1  din valid
- in_ready  output  1  encoder can accept din this cycle
- out_data  output  32  encoded instruction word
- out_addr  output  ADDR_W  byte address for out_data
- out_valid  output  1  out_data/out_addr valid
- out_ready  input  1  sink accepts word
- err_pulse  output  1  one-cycle pulse: accepted din was rejected
- err_sticky  output  1  set on any rejection; cleared only by reset

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk_in, rst_in).
- Reset values: out_valid=0, out_data=0, out_addr=BASE_ADDR, err_pulse=0, err_sticky=0, state=S_IDLE, word count=0.
- Reset mid-operation discards a held or pending second word.
- Handshakes:
  - in_ready = (state==S_IDLE) && (!out_valid || out_ready).
  - Input accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
  - out_data and out_addr are held stable while out_valid && !out_ready.
- Latency: word appears on out_* the cycle after accept. Full throughput of 1 word/cycle when out_ready is held high.
- Address: out_addr = BASE_ADDR + 4*count. count increments on each output transfer only; rejected inputs do not advance it.
- FSM:
  - S_IDLE: on accept, encode din.
    - Error: err_pulse=1 and err_sticky=1 next cycle; out_valid is not set.
    - Single word: load out register, out_valid=1.
    - Expansion: load first word and latch second word; go to S_SECOND.
  - S_SECOND: in_ready=0. On output transfer, load the second word, out_valid stays 1, return to S_IDLE.
- Encoding: standard RV32I opcodes, funct3 and field placement.
  - SUB and SRA(I) use funct7=0100000; all others use 0000000.
  - JALR uses funct3=000.
  - Fields not used by an itype are ignored.
- Rejection conditions:
  - itype, alu_func, br_func or mem_func Unsupported.
  - I/S-type imm outside -2048..2047.
  - Shift imm outside 0..31.
  - BRANCH imm outside -4096..4094, or imm odd.
  - JAL imm outside -2^20..2^20-2, or imm odd.
  - LUI/AUIPC imm[11:0] != 0.
- Precedence: an out-of-range OPIMM ADD imm is checked against expansion first (see Optional Feature).

Optional Feature:
- Macro: ENC_LI_EXPAND_EN.
- Defined: OPIMM ADD with imm outside 12-bit range and src1==0 expands to two words.
  - hi = (imm + 32'h800) >> 12; lo = imm - (hi<<12).
  - Emits LUI dst,hi, then ADDI dst,dst,lo.
  - If lo==0, only the LUI is emitted and the FSM stays in S_IDLE.
  - src1!=0 with an out-of-range imm is rejected.
- Undefined: S_SECOND is never entered; every out-of-range OPIMM imm is rejected.

Test Plan:
- OPIMM ADD dst=1 src1=0 imm=5 -> out_data=32'h00500093, out_addr=BASE_ADDR, one cycle after accept.
- OP SUB dst=3 src1=1 src2=2, then BRANCH EQ src1=1 src2=2 imm=8 -> 32'h402081B3 at BASE, then 32'h00208463 at BASE+4, back-to-back with out_ready=1.
- out_ready low 3 cycles while out_valid=1 -> out_data/out_addr unchanged, in_ready=0; transfer on the 4th cycle.
- ENC_LI_EXPAND_EN defined: OPIMM ADD dst=5 src1=0 imm=32'h12345678 -> 32'h123452B7 at BASE, then 32'h67828293 at BASE+4, in_ready=0 until the second word is loaded. Undefined: same input -> err_pulse, no output.
- BRANCH imm=3 -> err_pulse one cycle, err_sticky=1, no out_valid. Following OPIMM ADD dst=1 imm=5 -> emitted at BASE_ADDR (count not advanced).
- Assert rst_in in S_SECOND with out_valid=1 -> out_valid=0 immediately, state S_IDLE. Next word at BASE_ADDR; err_sticky=0.
